// File: rtl/cache_responder_if.sv
// Processor-command and backing-memory signals of the cache controller.
// The slave modport is the cache side; the master modport is the processor/memory side.
`default_nettype none

interface cache_responder_if #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 6
);
  logic                     REQ;
  logic                     READrWRITE;
  logic [INDEX_W-1:0]       INDEX;
  logic [TAG_W-1:0]         TAG;
  logic [1:0]               BYTESELECT;
  logic                     STALL;
  logic                     HIT;
  logic                     MISS;
  logic                     mem_req;
  logic                     mem_we;
  logic [TAG_W+INDEX_W+1:0] mem_addr;
  logic [7:0]               mem_wdata;
  logic [31:0]              mem_rdata;
  logic                     mem_ack;

  modport slave (
    input  REQ, READrWRITE, INDEX, TAG, BYTESELECT,
    output STALL, HIT, MISS,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output REQ, READrWRITE, INDEX, TAG, BYTESELECT,
    input  STALL, HIT, MISS,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/cache_responder.sv
// cache_responder: direct-mapped, write-through, no-write-allocate data cache controller.
// Optional CACHE_STATS_EN adds saturating hit/miss lookup counters.
`default_nettype none

module cache_responder #(
  parameter int INDEX_W    = 8,
  parameter int TAG_W      = 6,
  parameter int LINE_BYTES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  cache_responder_if.slave      bus,
`ifdef CACHE_STATS_EN
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count,
`endif
  inout  wire  [7:0]            Data
);

  localparam int NUM_LINES = 2 ** INDEX_W;
  localparam int LINE_W    = LINE_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_FILL    = 3'd2,
    S_WRMEM   = 3'd3,
    S_RESPOND = 3'd4
  } state_e;

  state_e                   state_q;
  logic                     rw_q;
  logic [INDEX_W-1:0]       idx_q;
  logic [TAG_W-1:0]         tag_q;
  logic [1:0]               bsel_q;
  logic [7:0]               wbyte_q;
  logic [NUM_LINES-1:0]     valid_q;
  logic [TAG_W-1:0]         tag_mem_q  [NUM_LINES];
  logic [LINE_W-1:0]        data_mem_q [NUM_LINES];
  logic                     stall_q, hit_q, miss_q;
  logic                     mem_req_q, mem_we_q;
  logic [TAG_W+INDEX_W+1:0] mem_addr_q;
  logic [7:0]               mem_wdata_q;
  logic                     drive_q;
  logic [7:0]               rdbyte_q;

  logic                     lookup_hit;
  logic [LINE_W-1:0]        cur_line;
  logic                     line_we, tag_we;
  logic [LINE_W-1:0]        line_wdata;

  assign cur_line   = data_mem_q[idx_q];
  assign lookup_hit = valid_q[idx_q] && (tag_mem_q[idx_q] == tag_q);

  function automatic logic [7:0] byte_of(input logic [LINE_W-1:0] line, input logic [1:0] sel);
    return line[{sel, 3'b000} +: 8];
  endfunction

  // Single write port into the line storage: byte merge on write hit, full line on fill.
  always_comb begin
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_wdata = cur_line;
    if (state_q == S_LOOKUP && !rw_q && lookup_hit) begin
      line_we                           = 1'b1;
      line_wdata[{bsel_q, 3'b000} +: 8] = wbyte_q;
    end else if (state_q == S_FILL && bus.mem_ack) begin
      line_we    = 1'b1;
      tag_we     = 1'b1;
      line_wdata = bus.mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (line_we) data_mem_q[idx_q] <= line_wdata;
    if (tag_we)  tag_mem_q[idx_q]  <= tag_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      idx_q       <= '0;
      tag_q       <= '0;
      bsel_q      <= '0;
      wbyte_q     <= '0;
      valid_q     <= '0;
      stall_q     <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      drive_q     <= 1'b0;
      rdbyte_q    <= '0;
`ifdef CACHE_STATS_EN
      hit_count   <= '0;
      miss_count  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.REQ) begin
            rw_q    <= bus.READrWRITE;
            idx_q   <= bus.INDEX;
            tag_q   <= bus.TAG;
            bsel_q  <= bus.BYTESELECT;
            wbyte_q <= Data;
            stall_q <= 1'b1;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          hit_q  <= lookup_hit;
          miss_q <= !lookup_hit;
`ifdef CACHE_STATS_EN
          if (lookup_hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
          if (!lookup_hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
`endif
          if (rw_q && lookup_hit) begin
            stall_q  <= 1'b0;
            drive_q  <= 1'b1;
            rdbyte_q <= byte_of(cur_line, bsel_q);
            state_q  <= S_RESPOND;
          end else if (rw_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag_q, idx_q, 2'b00};
            state_q    <= S_FILL;
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {tag_q, idx_q, bsel_q};
            mem_wdata_q <= wbyte_q;
            state_q     <= S_WRMEM;
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            valid_q[idx_q] <= 1'b1;
            mem_req_q      <= 1'b0;
            stall_q        <= 1'b0;
            drive_q        <= 1'b1;
            rdbyte_q       <= byte_of(bus.mem_rdata, bsel_q);
            state_q        <= S_RESPOND;
          end
        end
        S_WRMEM: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            stall_q   <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_RESPOND: begin
          drive_q <= 1'b0;
          hit_q   <= 1'b0;
          miss_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.STALL     = stall_q;
  assign bus.HIT       = hit_q;
  assign bus.MISS      = miss_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign Data          = drive_q ? rdbyte_q : 'z;

endmodule

`default_nettype wire
